// File: rtl/uart_regif_initiator.sv
// Bus-master for the UART register interface: issues one-cycle register accesses,
// retries SLVERR responses with a programmable gap and returns the final result.
module uart_regif_initiator #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_RETRY  = 15,
  parameter int RETRY_GAP  = 4
) (
  input  logic                    clk_i,
  input  logic                    arst_ni,
  input  logic                    cmd_valid_i,
  output logic                    cmd_ready_o,
  input  logic                    cmd_write_i,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr_i,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] cmd_wstrb_i,
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
  output logic [1:0]              rsp_resp_o,
  output logic [7:0]              rsp_retries_o,
  output logic                    mem_we_o,
  output logic [ADDR_WIDTH-1:0]   mem_waddr_o,
  output logic [DATA_WIDTH-1:0]   mem_wdata_o,
  output logic [DATA_WIDTH/8-1:0] mem_wstrb_o,
  input  logic [1:0]              mem_wresp_i,
  output logic                    mem_re_o,
  output logic [ADDR_WIDTH-1:0]   mem_raddr_o,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_i,
  input  logic [1:0]              mem_rresp_i,
  output logic                    busy_o
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_WAIT   = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic                      w_write_nxt;
  logic [1:0]                w_att_resp;
  logic                      w_last;

  logic                      r_write;
  logic [ADDR_WIDTH-1:0]     r_addr;
  logic [DATA_WIDTH-1:0]     r_wdata;
  logic [DATA_WIDTH/8-1:0]   r_wstrb;
  logic [7:0]                r_retries;
  logic [7:0]                r_gap;
  logic [DATA_WIDTH-1:0]     r_rdata;
  logic [1:0]                r_resp;
  logic                      r_rsp_valid;
  logic                      r_cmd_ready;
  logic                      r_busy;
  logic                      r_we;
  logic                      r_re;

  assign w_att_resp = r_write ? mem_wresp_i : mem_rresp_i;
  assign w_last     = (r_retries == 8'(MAX_RETRY));

  // Next-state decode; w_write_nxt lets the strobes be registered from the next state
  always_comb begin
    w_state_nxt = r_state;
    w_write_nxt = r_write;
    case (r_state)
      S_IDLE: begin
        if (cmd_valid_i) begin
          w_state_nxt = S_ACCESS;
          w_write_nxt = cmd_write_i;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_ACCESS: begin
        if (w_att_resp == 2'b00) begin
          w_state_nxt = S_RESP;
        end else if (w_last) begin
          w_state_nxt = S_RESP;
        end else if (RETRY_GAP == 0) begin
          w_state_nxt = S_ACCESS;
        end else begin
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (r_gap <= 8'd1) begin
          w_state_nxt = S_ACCESS;
        end else begin
          w_state_nxt = S_WAIT;
        end
      end
      S_RESP: begin
        if (rsp_ready_i) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_RESP;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Registered status/strobe outputs, command latch, retry bookkeeping and result capture
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      r_cmd_ready <= 1'b1;
      r_busy      <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_we        <= 1'b0;
      r_re        <= 1'b0;
      r_write     <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_wstrb     <= '0;
      r_retries   <= 8'd0;
      r_gap       <= 8'd0;
      r_rdata     <= '0;
      r_resp      <= 2'b00;
    end else begin
      r_cmd_ready <= (w_state_nxt == S_IDLE);
      r_busy      <= (w_state_nxt != S_IDLE);
      r_rsp_valid <= (w_state_nxt == S_RESP);
      r_we        <= (w_state_nxt == S_ACCESS) && w_write_nxt;
      r_re        <= (w_state_nxt == S_ACCESS) && !w_write_nxt;
      case (r_state)
        S_IDLE: begin
          if (cmd_valid_i) begin
            r_write   <= cmd_write_i;
            r_addr    <= cmd_addr_i;
            r_wdata   <= cmd_wdata_i;
            r_wstrb   <= cmd_wstrb_i;
            r_retries <= 8'd0;
          end
        end
        S_ACCESS: begin
          if (w_att_resp == 2'b00) begin
            r_resp  <= 2'b00;
            r_rdata <= r_write ? '0 : mem_rdata_i;
          end else if (w_last) begin
            r_resp  <= 2'b10;
            r_rdata <= '0;
          end else begin
            r_retries <= r_retries + 8'd1;
            r_gap     <= 8'(RETRY_GAP);
          end
        end
        S_WAIT: begin
          r_gap <= r_gap - 8'd1;
        end
        default: begin
          r_gap <= r_gap;
        end
      endcase
    end
  end

  assign cmd_ready_o   = r_cmd_ready;
  assign busy_o        = r_busy;
  assign rsp_valid_o   = r_rsp_valid;
  assign rsp_rdata_o   = r_rdata;
  assign rsp_resp_o    = r_resp;
  assign rsp_retries_o = r_retries;
  assign mem_we_o      = r_we;
  assign mem_re_o      = r_re;
  assign mem_waddr_o   = r_addr;
  assign mem_raddr_o   = r_addr;
  assign mem_wdata_o   = r_wdata;
  assign mem_wstrb_o   = r_wstrb;

endmodule

// File: tb/tb_uart_regif_initiator.sv
// Bench for uart_regif_initiator: directed table, randomized commands against a
// retry/outcome model, reset during back-off, back-to-back commands and a gap-0 instance.
module tb_uart_regif_initiator;
  localparam int AW = 6;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int MAXR = 15;
  localparam int GAP = 4;
  localparam logic [AW-1:0] REG_CLK_DIV_ADDR = 6'h04;
  localparam logic [AW-1:0] REG_RX_FIFO_DATA_ADDR = 6'h00;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic arst_n;
  logic cmd_valid, cmd_valid2, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic [SW-1:0] cmd_wstrb;
  logic rsp_ready, rsp_ready2;

  logic cmd_ready, rsp_valid, mem_we, mem_re, busy;
  logic [DW-1:0] rsp_rdata, mem_wdata;
  logic [1:0] rsp_resp, mem_wresp, mem_rresp;
  logic [7:0] rsp_retries;
  logic [AW-1:0] mem_waddr, mem_raddr;
  logic [SW-1:0] mem_wstrb;
  logic [DW-1:0] mem_rdata;

  logic cmd_ready2, rsp_valid2, mem_we2, mem_re2, busy2;
  logic [DW-1:0] rsp_rdata2, mem_wdata2;
  logic [1:0] rsp_resp2;
  logic [7:0] rsp_retries2;
  logic [AW-1:0] mem_waddr2, mem_raddr2;
  logic [SW-1:0] mem_wstrb2;

  // responder: fail the first nfail attempts of the current command, then OKAY
  int nfail = 0;
  int cmd_start = 0;
  int pulse_total = 0;
  logic [DW-1:0] tb_rdata = '0;
  assign mem_rresp = ((pulse_total - cmd_start) < nfail) ? 2'b10 : 2'b00;
  assign mem_wresp = ((pulse_total - cmd_start) < nfail) ? 2'b11 : 2'b00;
  assign mem_rdata = tb_rdata ^ {{(DW-AW){1'b0}}, mem_raddr};

  uart_regif_initiator #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_RETRY(MAXR), .RETRY_GAP(GAP)) u_dut (
    .clk_i(clk), .arst_ni(arst_n),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_write_i(cmd_write),
    .cmd_addr_i(cmd_addr), .cmd_wdata_i(cmd_wdata), .cmd_wstrb_i(cmd_wstrb),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata),
    .rsp_resp_o(rsp_resp), .rsp_retries_o(rsp_retries),
    .mem_we_o(mem_we), .mem_waddr_o(mem_waddr), .mem_wdata_o(mem_wdata), .mem_wstrb_o(mem_wstrb),
    .mem_wresp_i(mem_wresp), .mem_re_o(mem_re), .mem_raddr_o(mem_raddr),
    .mem_rdata_i(mem_rdata), .mem_rresp_i(mem_rresp), .busy_o(busy)
  );

  // second instance: always-SLVERR slave, MAX_RETRY=2, back-to-back retries
  uart_regif_initiator #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_RETRY(2), .RETRY_GAP(0)) u_dut2 (
    .clk_i(clk), .arst_ni(arst_n),
    .cmd_valid_i(cmd_valid2), .cmd_ready_o(cmd_ready2), .cmd_write_i(cmd_write),
    .cmd_addr_i(cmd_addr), .cmd_wdata_i(cmd_wdata), .cmd_wstrb_i(cmd_wstrb),
    .rsp_valid_o(rsp_valid2), .rsp_ready_i(rsp_ready2), .rsp_rdata_o(rsp_rdata2),
    .rsp_resp_o(rsp_resp2), .rsp_retries_o(rsp_retries2),
    .mem_we_o(mem_we2), .mem_waddr_o(mem_waddr2), .mem_wdata_o(mem_wdata2), .mem_wstrb_o(mem_wstrb2),
    .mem_wresp_i(2'b10), .mem_re_o(mem_re2), .mem_raddr_o(mem_raddr2),
    .mem_rdata_i(32'hFFFF_FFFF), .mem_rresp_i(2'b10), .busy_o(busy2)
  );

  // monitor: records strobe cycles and strobe-time violations against the expected command
  int cyc = 0;
  int pulse_q[$];
  int both_cnt = 0;
  int bad_cnt = 0;
  int pulse2_total = 0;
  logic mon_write = 1'b0;
  logic [AW-1:0] mon_addr = '0;
  logic [DW-1:0] mon_wdata = '0;
  logic [SW-1:0] mon_wstrb = '0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_we || mem_re) begin
      pulse_total <= pulse_total + 1;
      pulse_q.push_back(cyc);
      if (mem_we && mem_re) both_cnt <= both_cnt + 1;
      if (mem_we !== mon_write || mem_waddr !== mon_addr || mem_raddr !== mon_addr ||
          (mon_write && (mem_wdata !== mon_wdata || mem_wstrb !== mon_wstrb)))
        bad_cnt <= bad_cnt + 1;
    end
    if (mem_we2 || mem_re2) pulse2_total <= pulse2_total + 1;
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // reference outcome: fails beyond the retry budget end in SLVERR with zero data
  function automatic void model(input bit w, input logic [AW-1:0] addr, input int nf,
                                input logic [DW-1:0] rdat, output logic [1:0] resp,
                                output logic [7:0] ret, output logic [DW-1:0] rd);
    if (nf > MAXR) begin
      resp = 2'b10; ret = 8'(MAXR); rd = '0;
    end else begin
      resp = 2'b00; ret = 8'(nf);
      rd = w ? '0 : (rdat ^ {{(DW-AW){1'b0}}, addr});
    end
  endfunction

  task automatic run_cmd(input bit w, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                         input logic [SW-1:0] wstrb, input int nf, input logic [DW-1:0] rdat,
                         input logic [1:0] e_resp, input logic [7:0] e_ret,
                         input logic [DW-1:0] e_rdata, input int hold);
    int n, q0, b0, x0;
    bit stable;
    @(negedge clk);
    nfail = nf; tb_rdata = rdat; cmd_start = pulse_total;
    q0 = pulse_q.size(); b0 = both_cnt; x0 = bad_cnt;
    mon_write = w; mon_addr = addr; mon_wdata = wdata; mon_wstrb = wstrb;
    cmd_write = w; cmd_addr = addr; cmd_wdata = wdata; cmd_wstrb = wstrb; cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 20) begin @(negedge clk); n++; end
    chk("accept_wait", n, 0);
    @(negedge clk);
    cmd_valid = 1'b0;
    n = 1;
    while (!rsp_valid && n < 200) begin @(negedge clk); n++; end
    chk("rsp_latency", n, 2 + int'(e_ret) * (GAP + 1));
    chk("rsp_resp", rsp_resp, e_resp);
    chk("rsp_retries", rsp_retries, e_ret);
    chk("rsp_rdata", rsp_rdata, e_rdata);
    chk("pulse_count", pulse_q.size() - q0, int'(e_ret) + 1);
    chk("both_strobes", both_cnt - b0, 0);
    chk("strobe_fields", bad_cnt - x0, 0);
    for (int i = q0 + 1; i < pulse_q.size(); i++)
      chk("pulse_spacing", pulse_q[i] - pulse_q[i-1], GAP + 1);
    stable = 1'b1;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      if (!rsp_valid || rsp_resp !== e_resp || rsp_retries !== e_ret || rsp_rdata !== e_rdata ||
          cmd_ready || mem_we || mem_re || !busy) stable = 1'b0;
    end
    if (hold > 0) chk("resp_hold_stable", stable, 1'b1);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("idle_after_rsp", {busy, cmd_ready, rsp_valid}, 3'b010);
  endtask

  typedef struct {
    bit w; logic [AW-1:0] addr; logic [DW-1:0] wdata; logic [SW-1:0] wstrb; int nf;
    logic [DW-1:0] rdat; logic [1:0] e_resp; logic [7:0] e_ret; logic [DW-1:0] e_rdata; int hold;
  } vec_t;
  vec_t tbl[6];

  initial begin
    logic [1:0] m_resp;
    logic [7:0] m_ret;
    logic [DW-1:0] m_rd;
    logic [DW-1:0] rq[$];
    int n, p0, acc, acc_k;
    bit drop, ready_ok;
    bit rw;
    logic [AW-1:0] ra;
    int rn;

    tbl[0] = '{1'b1, REG_CLK_DIV_ADDR, 32'h64, 4'hF, 0, 32'h0, 2'b00, 8'd0, 32'h0, 0};
    tbl[1] = '{1'b0, REG_RX_FIFO_DATA_ADDR, 32'h0, 4'h0, 3, 32'h5A, 2'b00, 8'd3, 32'h5A, 10};
    tbl[2] = '{1'b0, 6'h08, 32'h0, 4'h0, 15, 32'h1234_5678, 2'b00, 8'd15, 32'h1234_5670, 0};
    tbl[3] = '{1'b0, 6'h08, 32'h0, 4'h0, 16, 32'h1234_5678, 2'b10, 8'd15, 32'h0, 0};
    tbl[4] = '{1'b1, 6'h3F, 32'hDEAD_BEEF, 4'h5, 30, 32'h0, 2'b10, 8'd15, 32'h0, 2};
    tbl[5] = '{1'b1, 6'h10, 32'h1, 4'h8, 1, 32'h0, 2'b00, 8'd1, 32'h0, 0};

    arst_n = 1'b0; cmd_valid = 1'b0; cmd_valid2 = 1'b0; cmd_write = 1'b0;
    cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0; rsp_ready = 1'b0; rsp_ready2 = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_ctrl", {cmd_ready, rsp_valid, mem_we, mem_re, busy}, 5'b10000);
    chk("reset_data", {rsp_rdata, rsp_resp, rsp_retries, mem_waddr, mem_wdata, mem_wstrb}, 64'h0);
    arst_n = 1'b1;

    for (int i = 0; i < 6; i++)
      run_cmd(tbl[i].w, tbl[i].addr, tbl[i].wdata, tbl[i].wstrb, tbl[i].nf, tbl[i].rdat,
              tbl[i].e_resp, tbl[i].e_ret, tbl[i].e_rdata, tbl[i].hold);

    for (int i = 0; i < 20; i++) begin
      rw = 1'($urandom_range(0, 1));
      ra = AW'($urandom);
      rn = $urandom_range(0, 17);
      tb_rdata = $urandom;
      model(rw, ra, rn, tb_rdata, m_resp, m_ret, m_rd);
      run_cmd(rw, ra, $urandom, SW'($urandom), rn, tb_rdata, m_resp, m_ret, m_rd,
              $urandom_range(0, 3));
    end

    // reset while backing off between attempts
    @(negedge clk);
    nfail = 5; cmd_start = pulse_total; tb_rdata = 32'h77;
    mon_write = 1'b0; mon_addr = 6'h21;
    cmd_write = 1'b0; cmd_addr = 6'h21; cmd_valid = 1'b1;
    n = 0;
    while (pulse_total == cmd_start && n < 20) begin
      @(negedge clk); n++;
      cmd_valid = 1'b0;
    end
    chk("first_attempt_seen", pulse_total - cmd_start, 1);
    @(negedge clk);
    chk("in_wait_busy", {busy, mem_re, rsp_retries}, {1'b1, 1'b0, 8'd1});
    arst_n = 1'b0;
    #1;
    chk("midreset_ctrl", {cmd_ready, rsp_valid, mem_we, mem_re, busy}, 5'b10000);
    chk("midreset_data", {rsp_rdata, rsp_resp, rsp_retries, mem_raddr, mem_wdata, mem_wstrb}, 64'h0);
    p0 = pulse_total;
    repeat (6) @(negedge clk);
    arst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("no_strobe_after_reset", pulse_total - p0, 0);
    chk("ready_after_reset", {cmd_ready, busy}, 2'b10);
    run_cmd(1'b0, 6'h21, 32'h0, 4'h0, 0, 32'h77, 2'b00, 8'd0, 32'h56, 0);

    // two back-to-back reads with cmd_valid held high
    @(negedge clk);
    nfail = 0; cmd_start = pulse_total; p0 = pulse_total; tb_rdata = 32'hC0DE_0000;
    mon_write = 1'b0; mon_addr = 6'h05;
    cmd_write = 1'b0; cmd_addr = 6'h05; cmd_valid = 1'b1; rsp_ready = 1'b1;
    acc = 0; acc_k = -1; drop = 1'b0; ready_ok = 1'b1;
    for (int k = 0; k < 12; k++) begin
      if (drop) begin cmd_valid = 1'b0; drop = 1'b0; end
      if (rsp_valid) rq.push_back(rsp_rdata);
      if (busy && cmd_ready) ready_ok = 1'b0;
      if (k == 2) begin cmd_addr = 6'h06; mon_addr = 6'h06; end
      if (cmd_valid && cmd_ready) begin
        acc++;
        if (acc == 2) begin drop = 1'b1; acc_k = k; end
      end
      @(negedge clk);
    end
    rsp_ready = 1'b0;
    chk("b2b_accepts", acc, 2);
    chk("b2b_second_accept_cycle", acc_k, 3);
    chk("b2b_accesses", pulse_total - p0, 2);
    chk("b2b_ready_low_busy", ready_ok, 1'b1);
    chk("b2b_rsp_count", rq.size(), 2);
    if (rq.size() == 2) begin
      chk("b2b_rsp0", rq[0], 32'hC0DE_0005);
      chk("b2b_rsp1", rq[1], 32'hC0DE_0006);
    end

    // gap-0 instance against a slave that never succeeds
    @(negedge clk);
    p0 = pulse2_total;
    cmd_write = 1'b0; cmd_addr = 6'h07; cmd_valid2 = 1'b1;
    chk("dut2_ready", cmd_ready2, 1'b1);
    @(negedge clk);
    cmd_valid2 = 1'b0;
    n = 1;
    while (!rsp_valid2 && n < 50) begin @(negedge clk); n++; end
    chk("dut2_latency", n, 4);
    chk("dut2_pulses", pulse2_total - p0, 3);
    chk("dut2_rsp", {rsp_resp2, rsp_retries2, rsp_rdata2}, {2'b10, 8'd2, 32'h0});
    rsp_ready2 = 1'b1;
    @(negedge clk);
    rsp_ready2 = 1'b0;
    chk("dut2_idle", {busy2, cmd_ready2}, 2'b01);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
